ex_muldiv: RTL and testbench

//  Execute-stage multiply/divide unit. Consumes aluop/reg1/reg2 from the ID/EX pipeline register.

---
 rtl/ex_muldiv_pkg.sv | 41 ++++
 rtl/ex_muldiv_if.sv | 29 ++
 rtl/ex_muldiv_div_core.sv | 58 +++++
 rtl/ex_muldiv.sv | 178 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared opcodes, divider FSM states and helpers for the EX mul/div unit.
// Ports: none (package). Opcodes follow the EXE_*_OP encoding of the ID stage.
// DIV_STEPS must equal DATA_W: one restoring iteration per quotient bit.
package ex_muldiv_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_0111;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  // stall[3] value meaning "EX stage is held by control"
  localparam logic STOP = 1'b1;

  // DivFree / DivByZero / DivOn / DivEnd
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Magnitude of a two's-complement word; 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic is_madd(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX operand bundle into the mul/div unit and its HI/LO result back out.
// master drives aluop/operands/forwarded HI-LO/stall/annul; slave returns hi/lo/whilo/stallreq.
// No handshake: the unit holds the pipeline through stallreq_o.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic [7:0]        aluop_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic [5:0]        stall;
  logic              annul_i;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              whilo_o;
  logic              stallreq_o;

  modport master (
    output aluop_i, reg1_i, reg2_i, hi_i, lo_i, stall, annul_i,
    input  hi_o, lo_o, whilo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, stall, annul_i,
    output hi_o, lo_o, whilo_o, stallreq_o
  );

endinterface

// File: rtl/ex_muldiv_div_core.sv
// ex_muldiv_div_core: restoring divider datapath, one quotient bit per step.
// Ports: clk, rst (async active-low), load/step controls, unsigned dividend/divisor in; rem/quot/last out.
// Latency: STEPS step cycles after load; the owner FSM decides when to step (no internal backpressure).
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
#(
  parameter int STEPS = DIV_STEPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [STEPS-1:0] dividend,
  input  logic [STEPS-1:0] divisor,
  output logic [STEPS-1:0] rem,
  output logic [STEPS-1:0] quot,
  output logic             last
);

  localparam int CW = $clog2(STEPS);

  // {remainder, quotient}; the shift below widens it to the 65-bit working value
  logic [2*STEPS-1:0] acc;
  logic [STEPS-1:0]   dsor;
  logic [CW-1:0]      cnt;
  logic [2*STEPS:0]   shifted;
  logic [STEPS:0]     diff;
  logic [2*STEPS-1:0] acc_nxt;

  always_comb begin
    shifted = {acc, 1'b0};
    diff    = shifted[2*STEPS:STEPS] - {1'b0, dsor};
    // No borrow means the partial remainder covered the divisor: keep the
    // difference and shift in a 1; otherwise restore (keep the shift).
    if (!diff[STEPS]) acc_nxt = {diff[STEPS-1:0], shifted[STEPS-1:1], 1'b1};
    else              acc_nxt = shifted[2*STEPS-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      dsor <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= {{STEPS{1'b0}}, dividend};
      dsor <= divisor;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  assign rem  = acc[2*STEPS-1:STEPS];
  assign quot = acc[STEPS-1:0];
  assign last = (cnt == CW'(STEPS-1));

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit producing HI/LO and its write enable.
// Ports: clk, rst (async active-low), bus (ex_muldiv_if.slave). MULT/MULTU 0-cycle; DIV/DIVU stall 33 then result; /0 stalls 2.
// Holds IF..EX with stallreq_o; result held in DIV_END while stall[3] is STOP. MULDIV_MADD_EN adds two-cycle MADD/MSUB.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  div_state_t state, state_nxt;

  logic                div_op, signed_div, mul_op, signed_mul, divisor_zero;
  logic                core_load, core_step, core_last;
  logic [DATA_W-1:0]   core_rem, core_quot, dividend_in, divisor_in;
  logic                neg_q, neg_r, by_zero;
  logic [2*DATA_W-1:0] mul_a, mul_b, product;
  logic [DATA_W-1:0]   hi_v, lo_v;
  logic                whilo_v, stallreq_v;

  assign div_op       = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
  assign signed_div   = (bus.aluop_i == EXE_DIV_OP);
  assign mul_op       = (bus.aluop_i == EXE_MULT_OP) || (bus.aluop_i == EXE_MULTU_OP);
  assign divisor_zero = (bus.reg2_i == '0);

`ifdef MULDIV_MADD_EN
  logic                madd_op, madd_sub, phase, phase_nxt, prod_latch;
  logic [2*DATA_W-1:0] prod_q, acc_sum;
  logic                unused_inputs;
  assign madd_op    = is_madd(bus.aluop_i);
  assign madd_sub   = (bus.aluop_i == EXE_MSUB_OP) || (bus.aluop_i == EXE_MSUBU_OP);
  assign signed_mul = (bus.aluop_i == EXE_MULT_OP) || (bus.aluop_i == EXE_MADD_OP) ||
                      (bus.aluop_i == EXE_MSUB_OP);
  assign acc_sum    = madd_sub ? ({bus.hi_i, bus.lo_i} - prod_q) : ({bus.hi_i, bus.lo_i} + prod_q);
  assign unused_inputs = ^{bus.stall[5:4], bus.stall[2:0]};
`else
  logic unused_inputs;
  assign signed_mul    = (bus.aluop_i == EXE_MULT_OP);
  assign unused_inputs = ^{bus.stall[5:4], bus.stall[2:0], bus.hi_i, bus.lo_i};
`endif

  // One 64x64 multiply of sign- or zero-extended operands; the low 64 bits
  // are the correct signed or unsigned 32x32 product.
  assign mul_a   = signed_mul ? {{DATA_W{bus.reg1_i[DATA_W-1]}}, bus.reg1_i} : {{DATA_W{1'b0}}, bus.reg1_i};
  assign mul_b   = signed_mul ? {{DATA_W{bus.reg2_i[DATA_W-1]}}, bus.reg2_i} : {{DATA_W{1'b0}}, bus.reg2_i};
  assign product = mul_a * mul_b;

  // Divide-by-zero loads the raw dividend so it can be returned as HI untouched.
  assign dividend_in = (signed_div && !divisor_zero) ? mag(bus.reg1_i) : bus.reg1_i;
  assign divisor_in  = signed_div ? mag(bus.reg2_i) : bus.reg2_i;

  ex_muldiv_div_core #(.STEPS(DIV_STEPS)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .dividend (dividend_in),
    .divisor  (divisor_in),
    .rem      (core_rem),
    .quot     (core_quot),
    .last     (core_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_FREE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      by_zero <= 1'b0;
    end else if (core_load) begin
      neg_q   <= signed_div & (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1]);
      neg_r   <= signed_div & bus.reg1_i[DATA_W-1];
      by_zero <= divisor_zero;
    end
  end

`ifdef MULDIV_MADD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= 1'b0;
      prod_q <= '0;
    end else begin
      phase <= phase_nxt;
      if (prod_latch) prod_q <= product;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    hi_v       = '0;
    lo_v       = '0;
    whilo_v    = 1'b0;
    stallreq_v = 1'b0;
`ifdef MULDIV_MADD_EN
    phase_nxt  = phase;
    prod_latch = 1'b0;
`endif
    case (state)
      DIV_FREE: begin
        if (mul_op) begin
          {hi_v, lo_v} = product;
          whilo_v      = 1'b1;
        end else if (div_op && !bus.annul_i) begin
          core_load  = 1'b1;
          stallreq_v = 1'b1;
          state_nxt  = divisor_zero ? DIV_BY_ZERO : DIV_ON;
        end
`ifdef MULDIV_MADD_EN
        else if (madd_op && !bus.annul_i) begin
          if (!phase) begin
            prod_latch = 1'b1;
            stallreq_v = 1'b1;
            phase_nxt  = 1'b1;
          end else begin
            {hi_v, lo_v} = acc_sum;
            whilo_v      = 1'b1;
            phase_nxt    = 1'b0;
          end
        end
`endif
      end
      DIV_BY_ZERO: begin
        if (bus.annul_i) state_nxt = DIV_FREE;
        else begin
          stallreq_v = 1'b1;
          state_nxt  = DIV_END;
        end
      end
      DIV_ON: begin
        if (bus.annul_i) state_nxt = DIV_FREE;
        else begin
          stallreq_v = 1'b1;
          core_step  = 1'b1;
          if (core_last) state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        if (bus.annul_i) state_nxt = DIV_FREE;
        else begin
          whilo_v = 1'b1;
          if (by_zero) begin
            hi_v = core_quot;
            lo_v = '1;
          end else begin
            hi_v = neg_r ? -core_rem  : core_rem;
            lo_v = neg_q ? -core_quot : core_quot;
          end
          if (bus.stall[3] != STOP) state_nxt = DIV_FREE;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
`ifdef MULDIV_MADD_EN
    if (bus.annul_i || !madd_op) phase_nxt = 1'b0;
`endif
    // Outputs drop to zero the moment reset asserts, not at the next edge.
    if (!rst) begin
      hi_v       = '0;
      lo_v       = '0;
      whilo_v    = 1'b0;
      stallreq_v = 1'b0;
    end
  end

  assign bus.hi_o       = hi_v;
  assign bus.lo_o       = lo_v;
  assign bus.whilo_o    = whilo_v;
  assign bus.stallreq_o = stallreq_v;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against a plain-arithmetic model.
// Every cycle's outputs are compared at the falling edge against expectations set by the driver.
// MULDIV_MADD_EN selects the MADD/MSUB scenario instead of the "ignored opcode" one.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  string       tag    = "reset";
  logic [31:0] exp_hi, exp_lo;
  logic        exp_whilo, exp_stallreq;

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    if (op == EXE_MULT_OP) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    return p;
  endfunction

  // returns {HI, LO}
  function automatic logic [63:0] model_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == EXE_DIV_OP) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic bit is_active(input logic [7:0] op);
    bit act;
    act = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) || (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
`ifdef MULDIV_MADD_EN
    act = act || is_madd(op);
`endif
    return act;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checking ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (bus.hi_o !== exp_hi || bus.lo_o !== exp_lo ||
          bus.whilo_o !== exp_whilo || bus.stallreq_o !== exp_stallreq) begin
        n_fail++;
        $display("FAIL %s t=%0t: got hi=%h lo=%h whilo=%b stallreq=%b, want hi=%h lo=%h whilo=%b stallreq=%b",
                 tag, $time, bus.hi_o, bus.lo_o, bus.whilo_o, bus.stallreq_o,
                 exp_hi, exp_lo, exp_whilo, exp_stallreq);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- driving ----------------
  task automatic tick(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic an, input logic stp,
                      input logic [31:0] eh, input logic [31:0] el, input logic ew, input logic es);
    @(posedge clk);
    #1;
    bus.aluop_i  = op;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.annul_i  = an;
    bus.stall    = stp ? 6'b001111 : 6'b000000;
    exp_hi       = eh;
    exp_lo       = el;
    exp_whilo    = ew;
    exp_stallreq = es;
    chk_en       = 1'b1;
  endtask

  task automatic idle_tick();
    tick(EXE_NOP_OP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Issue a divide: stall cycles (2 for /0, 33 otherwise), then the result,
  // optionally held by stall[3] for 'hold' extra cycles. annul_at picks the
  // cycle index (0 = issue cycle, n = result cycle) to flush; -1 = never.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int annul_at, input int hold,
                         input bit gap, input string t);
    int n;
    tag = t;
    n = (b == 32'd0) ? 2 : 33;
    for (int i = 0; i <= n; i++) begin
      if (i == annul_at) begin
        tick(op, a, b, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle_tick();
        return;
      end
      if (i < n) tick(op, a, b, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    end
    for (int h = 0; h < hold; h++)
      tick(op, a, b, 1'b0, 1'b1, res[63:32], res[31:0], 1'b1, 1'b0);
    tick(op, a, b, 1'b0, 1'b0, res[63:32], res[31:0], 1'b1, 1'b0);
    if (gap) idle_tick();
  endtask

  initial begin
    rst         = 1'b0;
    bus.aluop_i = EXE_NOP_OP;
    bus.reg1_i  = 32'd0;
    bus.reg2_i  = 32'd0;
    bus.hi_i    = 32'd0;
    bus.lo_i    = 32'd0;
    bus.stall   = 6'd0;
    bus.annul_i = 1'b0;

    // Model pinned to hand-worked results
    check("pin div 7/-2",      model_div(EXE_DIV_OP, 32'd7, -32'sd2),       {32'd1, 32'hFFFF_FFFD});
    check("pin div -9/4",      model_div(EXE_DIV_OP, -32'sd9, 32'd4),       {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    check("pin divu 100/7",    model_div(EXE_DIVU_OP, 32'd100, 32'd7),      {32'd2, 32'd14});
    check("pin div ovf",       model_div(EXE_DIV_OP, 32'h8000_0000, '1),    {32'd0, 32'h8000_0000});
    check("pin mult -3*5",     model_mul(EXE_MULT_OP, -32'sd3, 32'd5),      64'hFFFF_FFFF_FFFF_FFF1);
    check("pin multu max*max", model_mul(EXE_MULTU_OP, '1, '1),             64'hFFFF_FFFE_0000_0001);

    // Reset: outputs zero even with a divide presented
    tag = "reset";
    tick(EXE_DIV_OP, 32'd7, -32'sd2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_tick();
    rst = 1'b1;
    idle_tick();

    run_div(EXE_DIV_OP, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, -1, 0, 1'b1, "div 7/-2");
    run_div(EXE_DIVU_OP, 32'h8000_0000, 32'd0, {32'h8000_0000, 32'hFFFF_FFFF}, -1, 0, 1'b1, "divu /0");

    tag = "mult -3*5";
    tick(EXE_MULT_OP, -32'sd3, 32'd5, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0);
    tag = "multu";
    tick(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    idle_tick();

    run_div(EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, 11, 0, 1'b1, "divu annul run10");
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, -1, 0, 1'b1, "divu 100/7");
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1, 2, 1'b0, "div ovf held");
    run_div(EXE_DIV_OP, -32'sd7, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, -1, 0, 1'b0, "div -7/0 b2b");
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 1'b1, "divu annul done");
    run_div(EXE_DIV_OP, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF}, 1, 0, 1'b1, "div annul dzero");
    run_div(EXE_DIV_OP, 32'd9, 32'd2, {32'd1, 32'd4}, 0, 0, 1'b1, "div annul idle");

    // Reset in the middle of RUN (cnt == 20)
    tag = "reset mid-run";
    for (int i = 0; i < 22; i++)
      tick(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    exp_stallreq = 1'b0;
    #1;
    check("reset immediate hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("reset immediate ctl", {62'd0, bus.whilo_o, bus.stallreq_o}, 64'd0);
    idle_tick();
    rst = 1'b1;
    run_div(EXE_DIV_OP, -32'sd9, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, -1, 0, 1'b1, "div -9/4 after rst");

`ifdef MULDIV_MADD_EN
    bus.hi_i = 32'd0;
    bus.lo_i = 32'h10;
    tag = "madd 4*5";
    tick(EXE_MADD_OP, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick(EXE_MADD_OP, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 32'h24, 1'b1, 1'b0);
    idle_tick();
    tag = "msub 3*-2";
    tick(EXE_MSUB_OP, 32'd3, -32'sd2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick(EXE_MSUB_OP, 32'd3, -32'sd2, 1'b0, 1'b0, 32'd0, 32'h16, 1'b1, 1'b0);
    idle_tick();
    tag = "msubu annulled";
    tick(EXE_MSUBU_OP, 32'd3, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick(EXE_MSUBU_OP, 32'd3, 32'd2, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_tick();
    bus.lo_i = 32'd0;
`else
    bus.hi_i = 32'd0;
    bus.lo_i = 32'h10;
    tag = "madd ignored";
    tick(EXE_MADD_OP, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(EXE_MSUBU_OP, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_tick();
    bus.lo_i = 32'd0;
`endif

    // Randomized mix
    for (int k = 0; k < 60; k++) begin
      int          sel, n, an_at;
      logic [31:0] a, b;
      logic [7:0]  op;
      logic [63:0] p;
      sel = $urandom_range(0, 5);
      a   = rnd_val();
      b   = rnd_val();
      case (sel)
        0, 1: begin
          op  = (sel == 0) ? EXE_MULT_OP : EXE_MULTU_OP;
          p   = model_mul(op, a, b);
          tag = "rand mul";
          tick(op, a, b, 1'b0, 1'($urandom_range(0, 1)), p[63:32], p[31:0], 1'b1, 1'b0);
          if ($urandom_range(0, 1) == 1) idle_tick();
        end
        2, 3, 5: begin
          op = (sel == 3) ? EXE_DIVU_OP : EXE_DIV_OP;
          if (sel == 5) b = 32'd0;
          else if (b == 32'd0) b = 32'd3;
          n     = (b == 32'd0) ? 2 : 33;
          an_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n)) : -1;
          run_div(op, a, b, model_div(op, a, b), an_at, $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), "rand div");
        end
        default: begin
          op = 8'($urandom);
          while (is_active(op)) op = 8'($urandom);
          tag = "rand other op";
          tick(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               32'd0, 32'd0, 1'b0, 1'b0);
        end
      endcase
    end
    idle_tick();

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
